// File: rtl/fancy_timer_ctrl.sv
// fancy_timer_ctrl: detects 1101, shifts in a DELAY_W-bit delay, counts (delay+1)*TICKS_PER_UNIT cycles, then holds done until ack.
// Optional macro FANCY_TIMER_ACK_ABORT_EN: ack during shift or count aborts back to S.
module fancy_timer_ctrl #(
    parameter int TICKS_PER_UNIT = 1000,
    parameter int DELAY_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    output logic               shift_ena,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);
    localparam int TW = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int BW = DELAY_W > 1 ? $clog2(DELAY_W) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_UNIT - 1);
    localparam logic [BW-1:0] BLAST = BW'(DELAY_W - 1);

    typedef enum logic [2:0] {S, S1, S11, S110, B, COUNT, WAIT} state_t;

    state_t             state, nstate;
    logic [DELAY_W-1:0] delay, ndelay, remaining, nrem;
    logic [TW-1:0]      tick, ntick;
    logic [BW-1:0]      bidx, nbidx;

    // Next-state and datapath update; B with bidx stands in for B0..B(DELAY_W-1)
    always_comb begin
        nstate = state;
        ndelay = delay;
        nrem   = remaining;
        ntick  = tick;
        nbidx  = bidx;
        case (state)
            S:    nstate = data ? S1 : S;
            S1:   nstate = data ? S11 : S;
            S11:  nstate = data ? S11 : S110;
            S110: begin
                nstate = data ? B : S;
                nbidx  = '0;
            end
            B: begin
                ndelay = {delay[DELAY_W-2:0], data};
                nbidx  = bidx + 1'b1;
                if (bidx == BLAST) begin
                    nstate = COUNT;
                    nrem   = ndelay;
                    ntick  = '0;
                end
            end
            COUNT: begin
                if (tick == TLAST) begin
                    ntick = '0;
                    if (remaining == '0) nstate = WAIT;
                    else nrem = remaining - 1'b1;
                end else begin
                    ntick = tick + 1'b1;
                end
            end
            WAIT:    nstate = ack ? S : WAIT;
            default: nstate = S;
        endcase
`ifdef FANCY_TIMER_ACK_ABORT_EN
        if (ack && (state == B || state == COUNT)) begin
            nstate = S;
            nrem   = '0;
            ntick  = '0;
        end
`else
`endif
    end

    // State, datapath registers and outputs decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S;
            delay     <= '0;
            remaining <= '0;
            tick      <= '0;
            bidx      <= '0;
            shift_ena <= 1'b0;
            counting  <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            state     <= nstate;
            delay     <= ndelay;
            remaining <= nrem;
            tick      <= ntick;
            bidx      <= nbidx;
            shift_ena <= nstate == B;
            counting  <= nstate == COUNT;
            done      <= nstate == WAIT;
            count     <= nstate == COUNT ? nrem : '0;
        end
    end
endmodule

// File: tb/tb_fancy_timer_ctrl.sv
// tb_fancy_timer_ctrl: directed bench for fancy_timer_ctrl with TICKS_PER_UNIT=4, DELAY_W=4.
module tb_fancy_timer_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data = 1'b0;
    logic       ack = 1'b0;
    logic       shift_ena, counting, done;
    logic [3:0] count;
    int         checks = 0;
    int         errors = 0;
    int         n;

    fancy_timer_ctrl #(.TICKS_PER_UNIT(4), .DELAY_W(4)) dut (
        .clk(clk), .reset(reset), .data(data), .ack(ack),
        .shift_ena(shift_ena), .counting(counting), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic a);
        data = d;
        ack  = a;
        @(posedge clk);
        #1;
        chk("exclusive", 32'($countones({shift_ena, counting, done}) <= 1), 1);
    endtask

    task automatic idle_zero(input string tag);
        chk(tag, {shift_ena, counting, done, count}, 0);
    endtask

    task automatic measure_count(input logic a, output int len);
        len = 0;
        while (counting && len < 200) begin
            len++;
            step(1'b0, a);
        end
    endtask

    initial begin
        logic [3:0] exp_cnt [12] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [7:0] near = 8'b1100_1101;
        step(0, 0);
        step(0, 0);
        idle_zero("reset_outputs");
        reset = 1'b0;

        // Basic run: 1101 then delay 0010
        step(1, 0); step(1, 0); step(0, 0);
        chk("basic_no_shift_yet", shift_ena, 0);
        step(1, 0);
        chk("basic_shift_rise", shift_ena, 1);
        step(0, 0); step(0, 0); step(1, 0);
        chk("basic_shift_last", shift_ena, 1);
        step(0, 0);
        chk("basic_counting_start", counting, 1);
        chk("basic_count0", count, exp_cnt[0]);
        for (int i = 1; i < 12; i++) begin
            step(0, 0);
            chk("basic_counting", counting, 1);
            chk("basic_count", count, exp_cnt[i]);
        end
        step(0, 0);
        chk("basic_done", done, 1);
        chk("basic_count_after", count, 0);
        n = 1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            n += int'(done);
        end
        ack = 1'b1;
        step(0, 1);
        n++;
        chk("basic_done_cycles", n, 6);
        idle_zero("basic_back_to_s");
        ack = 1'b0;

        // Overlapping 1s: 11101 then 0000
        step(1, 0); step(1, 0); step(1, 0); step(0, 0);
        chk("overlap_no_shift", shift_ena, 0);
        step(1, 0);
        chk("overlap_shift", shift_ena, 1);
        step(0, 0); step(0, 0); step(0, 0); step(0, 0);
        chk("overlap_count0", count, 0);
        measure_count(1'b0, n);
        chk("overlap_count_len", n, 4);
        chk("overlap_done", done, 1);
        step(0, 1);
        chk("overlap_ack_now", done, 0);

        // Near miss: 11001101, shift only after the final 1
        for (int i = 7; i >= 1; i--) begin
            step(near[i], 0);
            chk("near_no_shift", shift_ena, 0);
        end
        step(near[0], 0);
        chk("near_shift", shift_ena, 1);
        step(0, 0); step(0, 0); step(0, 0); step(1, 0);
        chk("near_count1", count, 1);

        // Reset at cycle 6 of COUNT
        for (int i = 0; i < 5; i++) step(0, 0);
        chk("rst_still_counting", counting, 1);
        chk("rst_count_second_unit", count, 0);
        reset = 1'b1;
        step(0, 0);
        idle_zero("rst_outputs");
        reset = 1'b0;
        step(1, 0); step(1, 0); step(0, 0); step(1, 0);
        chk("rst_fresh_shift", shift_ena, 1);
        step(0, 0); step(0, 0); step(1, 0); step(1, 0);
        chk("rst_fresh_count3", count, 3);
        measure_count(1'b0, n);
        chk("rst_fresh_len", n, 16);
        chk("rst_fresh_done", done, 1);
        step(0, 1);
        idle_zero("rst_fresh_idle");

`ifdef FANCY_TIMER_ACK_ABORT_EN
        // Abort: delay 15, ack pulse during COUNT
        step(1, 0); step(1, 0); step(0, 0); step(1, 0);
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        chk("abort_count15", count, 15);
        for (int i = 0; i < 20; i++) step(0, 0);
        chk("abort_counting_before", counting, 1);
        step(0, 1);
        idle_zero("abort_cleared");
        n = 0;
        for (int i = 0; i < 80; i++) begin
            step(0, 0);
            n += int'(done);
        end
        chk("abort_no_done", n, 0);
        step(1, 0); step(1, 0); step(0, 0); step(1, 0);
        chk("abort_new_detect", shift_ena, 1);
`else
        // ack high through shift and COUNT is ignored; done lasts one cycle
        step(1, 0); step(1, 0); step(0, 0); step(1, 0);
        step(0, 1); step(0, 1); step(0, 1); step(1, 1);
        chk("ackhold_count1", count, 1);
        measure_count(1'b1, n);
        chk("ackhold_len", n, 8);
        chk("ackhold_done", done, 1);
        step(0, 1);
        idle_zero("ackhold_done_one_cycle");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fancy_timer_ctrl.md
# fancy_timer_ctrl

Sequencing controller for the one-hot timer datapath. Scans a serial bit stream for the start pattern 1101, shifts in a 4-bit delay MSB-first, and counts (delay+1)×TICKS_PER_UNIT cycles. It then raises `done` and holds it until the user acknowledges. The block owns the state register, the delay shift register and the tick/unit counters that the one-hot next-state logic only describes combinationally.

## Interface
- `TICKS_PER_UNIT`, default 1000: cycles per delay unit; legal range ≥1.
- `DELAY_W`, default 4: delay field width, which is also the number of shift cycles.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  1  serial input stream, sampled every cycle.
- `ack`  in  1  user acknowledge of `done`.
- `shift_ena`  out  1  high during the DELAY_W shift cycles.
- `counting`  out  1  high while in COUNT.
- `done`  out  1  high while in WAIT.
- `count`  out  DELAY_W  remaining delay units in COUNT; 0 in all other states.

## Operation
- States: S, S1, S11, S110, B0..B(DELAY_W-1), COUNT, WAIT. Encoding is free; outputs must be glitch-free registered or state-decoded.
- S: `data`=1 goes to S1; otherwise stay in S.
- S1: `data`=1 goes to S11; otherwise go to S.
- S11: `data`=0 goes to S110; otherwise stay in S11, so overlapping 1s are accepted.
- S110: `data`=1 goes to B0; otherwise go to S.
- B0..B(DELAY_W-1):
  - `shift_ena`=1 in each of these states.
  - `delay <= {delay[DELAY_W-2:0], data}` on every cycle.
  - Each state advances unconditionally; the last goes to COUNT.
- COUNT:
  - `tick` counts from 0 to TICKS_PER_UNIT-1. At wrap, `remaining` decrements.
  - When `remaining`==0 and `tick`==TICKS_PER_UNIT-1, go to WAIT.
  - `remaining` loads from the fully shifted delay on entry. This includes the bit sampled in the last B state.
  - `tick` resets to 0 on entry.
- WAIT: `done`=1. `ack`=1 goes to S; otherwise stay.
- Ack handling: `ack` is ignored in every state except WAIT, unless the Configuration section says otherwise. `data` is ignored in B*, COUNT and WAIT; pattern search restarts only from S.
- Width rules:
  - `tick` is max(1,$clog2(TICKS_PER_UNIT)) bits wide.
  - `remaining` is DELAY_W bits wide and never underflows.
  - TICKS_PER_UNIT=1 makes COUNT last exactly delay+1 cycles.

## Timing
- Reset values:
  - Registers: state=S, `delay`=0, `remaining`=0, `tick`=0.
  - Outputs: `shift_ena`=0, `counting`=0, `done`=0, `count`=0.
- Reset wins over every other input, including mid-shift, mid-count and in WAIT. The first active cycle after reset is in S.
- Shift latency: when 1,1,0,1 are sampled at edges t0..t3, `shift_ena` is high in the cycles following t3 through t3+DELAY_W. The delay bits are sampled at edges t4..t(3+DELAY_W).
- Count length: `counting` is high for exactly (delay+1)×TICKS_PER_UNIT consecutive cycles.
- Count output: `count` equals delay during the first unit and decrements at each unit boundary. It shows 0 during the final unit.
- Done: `done` rises in the cycle after the last COUNT cycle and stays high until `ack` is sampled high.
  - If `ack` is already high in the first WAIT cycle, `done` is high for exactly one cycle.
  - The state is S on the following cycle.
- At most one of `shift_ena`, `counting` and `done` is high in any cycle.

## Configuration
- `FANCY_TIMER_ACK_ABORT_EN`
  - When defined: `ack`=1 sampled in any B* state or in COUNT aborts the operation. The next state is S, `remaining`/`tick`/`count` clear to 0, and `done` is never raised for that run.
  - When undefined: `ack` is ignored outside WAIT, and the full delay always completes.

## Test plan
- Basic run (TICKS_PER_UNIT=4, DELAY_W=4):
  - Stimulus: `data` 1,1,0,1 then 0,0,1,0 (delay=2).
  - Required: `shift_ena` high 4 cycles, then `counting` high 12 cycles with `count` showing 2,2,2,2,1,1,1,1,0,0,0,0.
  - Then `done`=1 until `ack`; the state returns to S.
- Overlapping pattern: stream 1,1,1,0,1 then 0000 -> `shift_ena` rises after the fifth bit; `counting` lasts 4 cycles (delay=0).
- Near-miss patterns: stream 1,1,0,0,1,1,0,1 -> no `shift_ena` after the first 1100; it rises only after the final 1.
- Ack timing:
  - `ack` held high throughout COUNT (macro undefined) -> `done` high exactly 1 cycle.
  - `ack` low for 5 WAIT cycles -> `done` high 5 cycles plus the ack cycle.
- Reset mid-operation: assert `reset` at cycle 6 of COUNT -> next cycle all outputs 0 and state S; a fresh 1101 pattern starts a new run normally.
- Abort (macro defined, delay=15, TICKS_PER_UNIT=1000): pulse `ack` after 100 COUNT cycles -> `counting`=0 and `count`=0 next cycle, `done` never asserts, and a new 1101 is detected.
